// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at the start edge into shadow registers and committed when the busy period ends.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDU_op,
  input  logic        md,
  input  logic        mt,
  input  logic        mf,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic signed [31:0] a_sgn_s, b_div_s, sq_s, sr_s;
  logic        [31:0] b_udiv_s, uq_s, ur_s;
  logic               ovf_s, dz_s;
  logic [31:0]        res_hi_s, res_lo_s;
  logic               mf_unused_s;

  // mf only stalls the decoder; the read mux is selected by MDU_op alone
  assign mf_unused_s = mf;

  assign smul_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul_s   = {32'd0, A} * {32'd0, B};
  assign dz_s     = (B == 32'd0);
  assign ovf_s    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign a_sgn_s  = A;
  // Substitute a divisor of 1 for the special cases so the dividers never see /0 or overflow
  assign b_div_s  = (dz_s || ovf_s) ? 32'sd1 : B;
  assign b_udiv_s = dz_s ? 32'd1 : B;
  assign sq_s     = a_sgn_s / b_div_s;
  assign sr_s     = a_sgn_s % b_div_s;
  assign uq_s     = A / b_udiv_s;
  assign ur_s     = A % b_udiv_s;

  // Result selection; divide by zero reloads the current HI/LO so the commit is a no-op
  always_comb begin
    res_hi_s = hi_q;
    res_lo_s = lo_q;
    case (MDU_op)
      3'd0: {res_hi_s, res_lo_s} = smul_s;
      3'd1: {res_hi_s, res_lo_s} = umul_s;
      3'd2: begin
        if (dz_s) begin
          res_hi_s = hi_q;
          res_lo_s = lo_q;
        end else if (ovf_s) begin
          res_hi_s = 32'd0;
          res_lo_s = 32'h8000_0000;
        end else begin
          res_hi_s = sr_s;
          res_lo_s = sq_s;
        end
      end
      3'd3: begin
        if (dz_s) begin
          res_hi_s = hi_q;
          res_lo_s = lo_q;
        end else begin
          res_hi_s = ur_s;
          res_lo_s = uq_s;
        end
      end
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // Next-state logic: start, mt writes, countdown and commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      IDLE: begin
        if (md && (MDU_op[2] == 1'b0)) begin
          state_d  = BUSY;
          cnt_d    = MDU_op[1] ? DIV_N : MULT_N;
          hi_tmp_d = res_hi_s;
          lo_tmp_d = res_lo_s;
        end else if (mt && (MDU_op == 3'd4)) begin
          hi_d = A;
        end else if (mt && (MDU_op == 3'd5)) begin
          lo_d = A;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  // Read port from committed registers only
  always_comb begin
    case (MDU_op)
      3'd6:    MDU_out = hi_q;
      3'd7:    MDU_out = lo_q;
      default: MDU_out = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  MDU_op;
  logic        md, mt, mf;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] MDU_out, HI, LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_op(MDU_op), .md(md), .mt(mt), .mf(mf),
    .A(A), .B(B), .busy(busy), .MDU_out(MDU_out), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = 64'(ua * ub); hi = p[63:32]; lo = p[31:0]; end
      3'd2: if (b != 32'd0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      3'd3: if (b != 32'd0) begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      default: ;
    endcase
  endfunction

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    n = op[1] ? 10 : 5;
    @(negedge clk);
    MDU_op = op; A = a; B = b; md = 1'b1;
    @(negedge clk);
    md = 1'b0; A = $urandom; B = $urandom;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_high", {31'd0, busy}, 32'd1);
      check("hi_hold", HI, m_hi);
      check("lo_hold", LO, m_lo);
    end
    @(negedge clk);
    check("busy_low", {31'd0, busy}, 32'd0);
    check("hi_result", HI, ehi);
    check("lo_result", LO, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    MDU_op = op; A = a; mt = 1'b1;
    @(negedge clk);
    mt = 1'b0;
    if (op == 3'd4) m_hi = a;
    else if (op == 3'd5) m_lo = a;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_hi", HI, m_hi);
    check("mt_lo", LO, m_lo);
  endtask

  task automatic read_mf(input logic [2:0] op);
    @(negedge clk);
    MDU_op = op; mf = 1'b1;
    #1;
    check("mdu_out", MDU_out, (op == 3'd6) ? m_hi : ((op == 3'd7) ? m_lo : 32'd0));
    mf = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF};

    reset = 1'b0; MDU_op = 3'd0; md = 1'b0; mt = 1'b0; mf = 1'b0; A = 32'd0; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Divide by zero keeps HI/LO
    do_mt(3'd4, 32'h11);
    do_mt(3'd5, 32'h22);
    run_md(3'd3, 32'd55, 32'd0, 32'h11, 32'h22);
    run_md(3'd2, 32'hFFFF_0000, 32'd0, 32'h11, 32'h22);

    // mthi then reads
    do_mt(3'd4, 32'h1234);
    read_mf(3'd7);
    read_mf(3'd6);
    read_mf(3'd3);

    // Ignored strobes: md with op 4, mt with op 0 and 6
    @(negedge clk);
    MDU_op = 3'd4; A = 32'hDEAD_BEEF; md = 1'b1;
    @(negedge clk);
    md = 1'b0;
    check("md_op4_busy", {31'd0, busy}, 32'd0);
    check("md_op4_hi", HI, m_hi);
    do_mt(3'd0, 32'hCAFE_0000);
    do_mt(3'd6, 32'hCAFE_0001);

    // md and mt together in IDLE: md wins
    @(negedge clk);
    MDU_op = 3'd0; A = 32'd6; B = 32'd7; md = 1'b1; mt = 1'b1;
    @(negedge clk);
    md = 1'b0; mt = 1'b0;
    check("md_mt_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd42;
    check("md_mt_hi", HI, m_hi);
    check("md_mt_lo", LO, m_lo);

    // Second md at busy cycle 3 and mt at cycle 4 are ignored
    @(negedge clk);
    MDU_op = 3'd0; A = 32'd3; B = 32'd4; md = 1'b1;
    @(negedge clk);
    md = 1'b0;
    @(negedge clk);
    @(negedge clk);
    MDU_op = 3'd3; A = 32'd100; B = 32'd7; md = 1'b1;
    @(negedge clk);
    md = 1'b0; MDU_op = 3'd4; A = 32'hDEAD_0000; mt = 1'b1;
    @(negedge clk);
    mt = 1'b0;
    check("busy_c5", {31'd0, busy}, 32'd1);
    check("busy_c5_hi", HI, m_hi);
    @(negedge clk);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("first_hi", HI, 32'd0);
    check("first_lo", LO, 32'd12);
    m_hi = 32'd0; m_lo = 32'd12;
    repeat (12) @(negedge clk);
    check("no_second", {31'd0, busy}, 32'd0);
    check("no_second_lo", LO, 32'd12);

    // Reset at busy cycle 4 of a div
    do_mt(3'd4, 32'h5555);
    @(negedge clk);
    MDU_op = 3'd2; A = 32'd1000; B = 32'd3; md = 1'b1;
    @(negedge clk);
    md = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);
    run_md(3'd0, 32'd3, 32'd4, 32'd0, 32'd12);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (op < 3'd4) begin
        ehi = m_hi; elo = m_lo;
        ref_md(op, a, b, ehi, elo);
        run_md(op, a, b, ehi, elo);
      end else begin
        do_mt(op, a);
      end
      read_mf(3'd6);
      read_mf(3'd7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MDU_op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
REQ-006 md  input  1  start strobe for MDU_op 0-3, issued from the E stage.
REQ-007 mt  input  1  write strobe for MDU_op 4-5.
REQ-008 mf  input  1  read select for MDU_op 6-7.
REQ-009 A  input  32  rs operand (dividend, multiplicand, mt data).
REQ-010 B  input  32  rt operand (divisor, multiplier).
REQ-011 busy  output  1  registered; high while an operation is in flight.
REQ-012 MDU_out  output  32  read data: HI when MDU_op=6, LO when MDU_op=7, else 0.
REQ-013 HI, LO  output  32 each  committed architectural registers.

Function
REQ-014 Two states, IDLE and BUSY, plus a 4-bit down-counter cnt and 32-bit shadow registers hi_tmp and lo_tmp.
REQ-015 In IDLE, md=1 with MDU_op 0-3 at edge E0: compute the result from A and B, latch it into hi_tmp/lo_tmp, load cnt with N (MULT_CYCLES or DIV_CYCLES), and enter BUSY.
REQ-016 busy = (state==BUSY); high for exactly N cycles after E0 (cycles E0+1 .. E0+N).
REQ-017 In BUSY, at each edge with cnt>1: cnt decrements.
REQ-018 In BUSY, at the edge with cnt==1: HI<=hi_tmp, LO<=lo_tmp, state<=IDLE; new HI/LO are visible in the cycle after busy falls.
REQ-019 mult: {HI,LO} = signed 64-bit product of A and B.
REQ-020 multu: {HI,LO} = unsigned 64-bit product of A and B.
REQ-021 div: LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-022 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-024 Divide by zero (B==0): the full busy period still elapses; HI and LO remain unchanged.
REQ-025 mt=1 in IDLE: mthi writes HI<=A and mtlo writes LO<=A at that edge; busy is not asserted.
REQ-026 md or mt asserted while busy: ignored; no state, HI, LO or shadow change (the decoder stalls on md/mf/mt while busy or start).
REQ-027 md and mt both asserted in the same IDLE cycle: md wins and mt is ignored.
REQ-028 md with MDU_op 4-7, or mt with MDU_op 0-3 or 6-7: ignored.
REQ-029 MDU_out is combinational from committed HI/LO, is independent of busy, and never exposes hi_tmp/lo_tmp.
REQ-030 The result is computed from A and B sampled at E0 only; later changes to A or B do not affect the result.

Reset
REQ-031 reset=0 forces, asynchronously: state=IDLE, busy=0, cnt=0, HI=0, LO=0, hi_tmp=0, lo_tmp=0.
REQ-032 Reset mid-operation aborts the operation, commits no result, and leaves HI=LO=0 after release.
REQ-033 The first md accepted after reset release starts normally from IDLE.

Verification
REQ-034 mult, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 multu, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO unchanged while busy.
REQ-036 div, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-037 With HI=0x11, LO=0x22, divu with B=0 -> 10 busy cycles; HI=0x11, LO=0x22 retained.
REQ-038 mthi A=0x1234, then mflo and mfhi reads -> MDU_out=LO, then 0x1234; md pulsed at busy cycle 3 of a mult is ignored, and only the first result commits.
REQ-039 reset pulled low at busy cycle 4 of a div -> busy=0 and HI=LO=0 immediately; no late commit after release.
